// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access controller: state encoding
// and the value returned on the load-data port when an access fails.
package dmem_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] S_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] S_REQ  = 2'd1;
  localparam logic [STATE_W-1:0] S_DONE = 2'd2;

  localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = S_IDLE,
    ST_REQ  = S_REQ,
    ST_DONE = S_DONE
  } state_e;

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Request watchdog: counts cycles while enabled and flags the last allowed
// cycle (count == TIMEOUT_CYC-1). Clear has priority over enable.
module dmem_timeout_cnt #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Saturate at the terminal count so the flag cannot wrap away.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Turns the CPU's single-cycle load/store into a req/ack memory handshake,
// stalling the CPU until the DONE (commit) cycle. Optional alignment
// check is enabled with the DMEM_ALIGN_CHECK_EN macro.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  input  logic              cpu_rd_i,
  input  logic              cpu_wr_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  output logic              cpu_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
  localparam logic [DATA_W-1:0] ERR_DATA  = DATA_W'(ERR_RDATA);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              cnt_clr, cnt_en, cnt_expired;

`ifdef DMEM_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = |cpu_addr_i[1:0];
`endif

  dmem_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (cnt_clr),
    .en_i      (cnt_en),
    .expired_o (cnt_expired)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    cpu_stall_o = 1'b0;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cpu_stall_o = cpu_rd_i | cpu_wr_i;
        err_d       = 1'b0;
        if (cpu_rd_i && cpu_wr_i) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
          rdata_d = ERR_DATA;
`ifdef DMEM_ALIGN_CHECK_EN
        end else if ((cpu_rd_i ^ cpu_wr_i) && misaligned) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
          rdata_d = ERR_DATA;
`endif
        end else if (cpu_rd_i ^ cpu_wr_i) begin
          state_d = ST_REQ;
          addr_d  = cpu_addr_i & WORD_MASK;
          wdata_d = cpu_wdata_i;
          we_d    = cpu_wr_i;
          cnt_clr = 1'b1;
        end
      end

      ST_REQ: begin
        cpu_stall_o = 1'b1;
        // An ack in the final watchdog cycle still completes the access.
        if (mem_ack_i) begin
          if (!we_q) begin
            rdata_d = mem_rdata_i;
          end
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_expired) begin
          err_d   = 1'b1;
          rdata_d = ERR_DATA;
          state_d = ST_DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        err_d   = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign mem_req_o   = (state_q == ST_REQ);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign cpu_rdata_o = rdata_q;
  assign cpu_err_o   = err_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed testbench for dmem_access_ctrl: loads, stores, timeout, illegal
// requests, reset mid-access, back-to-back and misaligned addresses.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        cpu_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .TIMEOUT_CYC (64)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cpu_addr_i  (cpu_addr),
    .cpu_wdata_i (cpu_wdata),
    .cpu_rd_i    (cpu_rd),
    .cpu_wr_i    (cpu_wr),
    .cpu_rdata_o (cpu_rdata),
    .cpu_stall_o (cpu_stall),
    .cpu_err_o   (cpu_err),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_ack_i   (mem_ack),
    .mem_rdata_i (mem_rdata)
  );

  // Drives one CPU access and plays the memory side; ack_at is the index of
  // the REQ cycle that gets the ack (-1 = never). Records what was observed.
  task automatic run_access(input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int ack_at, input logic [31:0] mem_data,
                            output int stall_n, output int req_n,
                            output logic [31:0] d_rdata, output logic d_err,
                            output logic [31:0] a_seen, output logic we_seen,
                            output logic [31:0] wd_seen, output logic stable,
                            output logic done_seen);
    stall_n = 0; req_n = 0; d_rdata = '0; d_err = 1'b0;
    a_seen = '0; we_seen = 1'b0; wd_seen = '0; stable = 1'b1; done_seen = 1'b0;
    @(negedge clk);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata; mem_ack = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      #1;
      if (cpu_stall) stall_n++;
      if (mem_req) begin
        if (req_n == 0) begin
          a_seen = mem_addr; we_seen = mem_we; wd_seen = mem_wdata;
        end else if (mem_addr !== a_seen || mem_we !== we_seen || mem_wdata !== wd_seen) begin
          stable = 1'b0;
        end
        if (req_n == ack_at) begin
          mem_ack = 1'b1; mem_rdata = mem_data;
        end
        req_n++;
      end
      if (cyc > 0 && !cpu_stall) begin
        d_rdata = cpu_rdata; d_err = cpu_err; done_seen = 1'b1;
        break;
      end
      if (cyc == 0 && !cpu_stall) begin
        break;
      end
      @(negedge clk);
      mem_ack = 1'b0;
    end
    @(negedge clk);
    cpu_rd = 1'b0; cpu_wr = 1'b0; mem_ack = 1'b0;
    $display("access rd=%0d wr=%0d addr=%h stall=%0d req=%0d rdata=%h err=%0d",
             rd, wr, addr, stall_n, req_n, d_rdata, d_err);
  endtask

  int          st_n, rq_n;
  logic [31:0] o_rdata, o_addr, o_wdata;
  logic        o_err, o_we, o_stable, o_done;

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (mem_req !== 1'b0) $display("FAIL reset_req got %b exp 0", mem_req); else n_pass++;
    n_checks++; if (cpu_stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", cpu_stall); else n_pass++;
    n_checks++; if (cpu_err !== 1'b0) $display("FAIL reset_err got %b exp 0", cpu_err); else n_pass++;
    n_checks++; if (cpu_rdata !== 32'h0) $display("FAIL reset_rdata got %h exp 0", cpu_rdata); else n_pass++;
    n_checks++; if (mem_addr !== 32'h0 || mem_we !== 1'b0 || mem_wdata !== 32'h0)
      $display("FAIL reset_mem got addr=%h we=%b wdata=%h exp zeros", mem_addr, mem_we, mem_wdata); else n_pass++;
    rst = 1'b1;
  endtask

  task automatic test_load();
    run_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0, 32'h1234_5678,
               st_n, rq_n, o_rdata, o_err, o_addr, o_we, o_wdata, o_stable, o_done);
    n_checks++; if (o_done !== 1'b1) $display("FAIL load_done got %b exp 1", o_done); else n_pass++;
    n_checks++; if (st_n != 2) $display("FAIL load_stall got %0d exp 2", st_n); else n_pass++;
    n_checks++; if (rq_n != 1) $display("FAIL load_req got %0d exp 1", rq_n); else n_pass++;
    n_checks++; if (o_addr !== 32'h10 || o_we !== 1'b0) $display("FAIL load_addr got %h we=%b exp 10 we=0", o_addr, o_we); else n_pass++;
    n_checks++; if (o_rdata !== 32'h1234_5678) $display("FAIL load_rdata got %h exp 12345678", o_rdata); else n_pass++;
    n_checks++; if (o_err !== 1'b0) $display("FAIL load_err got %b exp 0", o_err); else n_pass++;
  endtask

  task automatic test_store();
    run_access(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 5, 32'hFFFF_0000,
               st_n, rq_n, o_rdata, o_err, o_addr, o_we, o_wdata, o_stable, o_done);
    n_checks++; if (st_n != 7) $display("FAIL store_stall got %0d exp 7", st_n); else n_pass++;
    n_checks++; if (rq_n != 6) $display("FAIL store_req got %0d exp 6", rq_n); else n_pass++;
    n_checks++; if (o_we !== 1'b1 || o_addr !== 32'h20 || o_wdata !== 32'hCAFE_F00D)
      $display("FAIL store_bus got we=%b addr=%h wdata=%h exp 1 20 cafef00d", o_we, o_addr, o_wdata); else n_pass++;
    n_checks++; if (o_stable !== 1'b1) $display("FAIL store_stable got %b exp 1", o_stable); else n_pass++;
    n_checks++; if (o_err !== 1'b0) $display("FAIL store_err got %b exp 0", o_err); else n_pass++;
    n_checks++; if (o_rdata !== 32'h1234_5678) $display("FAIL store_rdata got %h exp 12345678", o_rdata); else n_pass++;
  endtask

  task automatic test_illegal();
    run_access(1'b1, 1'b1, 32'h0000_0030, 32'h5555_AAAA, 0, 32'h7777_7777,
               st_n, rq_n, o_rdata, o_err, o_addr, o_we, o_wdata, o_stable, o_done);
    n_checks++; if (rq_n != 0) $display("FAIL illegal_req got %0d exp 0", rq_n); else n_pass++;
    n_checks++; if (st_n != 1) $display("FAIL illegal_stall got %0d exp 1", st_n); else n_pass++;
    n_checks++; if (o_err !== 1'b1) $display("FAIL illegal_err got %b exp 1", o_err); else n_pass++;
    n_checks++; if (o_rdata !== 32'h0) $display("FAIL illegal_rdata got %h exp 0", o_rdata); else n_pass++;
  endtask

  task automatic test_timeout();
    run_access(1'b1, 1'b0, 32'h0000_0024, 32'h0, -1, 32'h0,
               st_n, rq_n, o_rdata, o_err, o_addr, o_we, o_wdata, o_stable, o_done);
    n_checks++; if (o_done !== 1'b1) $display("FAIL timeout_done got %b exp 1", o_done); else n_pass++;
    n_checks++; if (rq_n != 64) $display("FAIL timeout_req got %0d exp 64", rq_n); else n_pass++;
    n_checks++; if (st_n != 65) $display("FAIL timeout_stall got %0d exp 65", st_n); else n_pass++;
    n_checks++; if (o_err !== 1'b1 || o_rdata !== 32'h0) $display("FAIL timeout_result got err=%b rdata=%h exp 1 0", o_err, o_rdata); else n_pass++;
    mem_ack = 1'b1; mem_rdata = 32'hFEED_BEEF;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    n_checks++; if (mem_req !== 1'b0 || cpu_stall !== 1'b0 || cpu_err !== 1'b0 || cpu_rdata !== 32'h0)
      $display("FAIL spurious_ack got req=%b stall=%b err=%b rdata=%h exp 0 0 0 0", mem_req, cpu_stall, cpu_err, cpu_rdata); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [5:0]  stall_v, req_v;
    logic [31:0] r1, r2;
    stall_v = '0; req_v = '0; r1 = '0; r2 = '0;
    @(negedge clk);
    cpu_rd = 1'b1; cpu_addr = 32'h0000_0050;
    for (int c = 0; c < 6; c++) begin
      #1;
      stall_v[c] = cpu_stall; req_v[c] = mem_req;
      if (mem_req) begin
        mem_ack = 1'b1; mem_rdata = (c < 3) ? 32'h1111_AAAA : 32'h2222_BBBB;
      end
      if (c == 2) r1 = cpu_rdata;
      if (c == 5) r2 = cpu_rdata;
      @(negedge clk);
      mem_ack = 1'b0;
    end
    cpu_rd = 1'b0;
    $display("access b2b loads stall=%b req=%b rdata=%h,%h", stall_v, req_v, r1, r2);
    n_checks++; if (stall_v !== 6'b011011) $display("FAIL b2b_stall got %b exp 011011", stall_v); else n_pass++;
    n_checks++; if (req_v !== 6'b010010) $display("FAIL b2b_req got %b exp 010010", req_v); else n_pass++;
    n_checks++; if (r1 !== 32'h1111_AAAA || r2 !== 32'h2222_BBBB) $display("FAIL b2b_rdata got %h %h exp 1111aaaa 2222bbbb", r1, r2); else n_pass++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    cpu_rd = 1'b1; cpu_addr = 32'h0000_0040; cpu_wdata = 32'h1111_2222;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) $display("FAIL rstmid_pre got req=%b addr=%h exp 1 40", mem_req, mem_addr); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; cpu_rd = 1'b0;
    #1;
    n_checks++; if (mem_req !== 1'b0 || cpu_stall !== 1'b0) $display("FAIL rstmid_req got req=%b stall=%b exp 0 0", mem_req, cpu_stall); else n_pass++;
    n_checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_we !== 1'b0)
      $display("FAIL rstmid_bus got addr=%h wdata=%h we=%b exp zeros", mem_addr, mem_wdata, mem_we); else n_pass++;
    n_checks++; if (cpu_rdata !== 32'h0 || cpu_err !== 1'b0) $display("FAIL rstmid_cpu got rdata=%h err=%b exp 0 0", cpu_rdata, cpu_err); else n_pass++;
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_DEAD;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    n_checks++; if (cpu_rdata !== 32'h0 || mem_req !== 1'b0) $display("FAIL late_ack got rdata=%h req=%b exp 0 0", cpu_rdata, mem_req); else n_pass++;
    run_access(1'b1, 1'b0, 32'h0000_0044, 32'h0, 1, 32'hA5A5_0001,
               st_n, rq_n, o_rdata, o_err, o_addr, o_we, o_wdata, o_stable, o_done);
    n_checks++; if (st_n != 3 || o_rdata !== 32'hA5A5_0001 || o_err !== 1'b0)
      $display("FAIL post_reset_load got stall=%0d rdata=%h err=%b exp 3 a5a50001 0", st_n, o_rdata, o_err); else n_pass++;
  endtask

  task automatic test_misaligned();
    run_access(1'b1, 1'b0, 32'h0000_0013, 32'h0, 0, 32'h0BAD_F00D,
               st_n, rq_n, o_rdata, o_err, o_addr, o_we, o_wdata, o_stable, o_done);
`ifdef DMEM_ALIGN_CHECK_EN
    n_checks++; if (rq_n != 0 || st_n != 1) $display("FAIL misalign_req got req=%0d stall=%0d exp 0 1", rq_n, st_n); else n_pass++;
    n_checks++; if (o_err !== 1'b1 || o_rdata !== 32'h0) $display("FAIL misalign_err got err=%b rdata=%h exp 1 0", o_err, o_rdata); else n_pass++;
`else
    n_checks++; if (rq_n != 1 || o_addr !== 32'h10) $display("FAIL misalign_addr got req=%0d addr=%h exp 1 10", rq_n, o_addr); else n_pass++;
    n_checks++; if (o_err !== 1'b0 || o_rdata !== 32'h0BAD_F00D) $display("FAIL misalign_data got err=%b rdata=%h exp 0 0badf00d", o_err, o_rdata); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_illegal();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_misaligned();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
